prefetch_issue_scheduler: RTL and testbench

PREFETCH_ISSUE_SCHEDULER -- requirements
Module: prefetch_issue_scheduler

---
 rtl/prefetch_issue_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_prefetch_issue_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_issue_scheduler.sv
// Issue scheduler for a lower-level request port shared by demand misses and a small
// queue of best-offset prefetches; tracks outstanding requests and prefetch starvation.
module prefetch_issue_scheduler #(
  parameter int WIDTH        = 64,
  parameter int QDEPTH       = 8,
  parameter int MSHR_COUNT   = 16,
  parameter int PF_THRESHOLD = 12,
  parameter int STARVE_MAX   = 4,
  parameter int LOGLINE      = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dem_valid_i,
  input  logic [WIDTH-1:0]                 dem_address_i,
  output logic                             dem_ready_o,
  input  logic                             pf_valid_i,
  input  logic [WIDTH-1:0]                 pf_address_i,
  input  logic                             flush_i,
  input  logic                             lo_ready_i,
  input  logic                             lo_fill_i,
  output logic                             lo_valid_o,
  output logic [WIDTH-1:0]                 lo_address_o,
  output logic                             lo_is_prefetch_o,
  output logic [$clog2(MSHR_COUNT+1)-1:0]  outstanding_o,
  output logic [15:0]                      pf_drop_cnt_o,
  output logic [1:0]                       state_o
);

  localparam int LW  = WIDTH - LOGLINE;
  localparam int CW  = $clog2(MSHR_COUNT + 1);
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int SW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DEM = 2'd1,
    HOLD_PF  = 2'd2
  } state_t;

  state_t            state;

  logic [LW-1:0]     q_line [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [QCW-1:0]    q_cnt;
  logic [CW-1:0]     out_cnt;
  logic [SW-1:0]     starve;

  logic              q_empty;
  logic              q_full;
  logic              hs;
  logic              free;
  logic              fill_eff;
  logic              space_ok;
  logic              pf_elig;
  logic              force_pf;
  logic              dem_grant;
  logic              pf_grant;
  logic              dup_q;
  logic              dup_out;
  logic              pf_enq;
  logic              pf_drop;
  logic [CW-1:0]     cnt_after_fill;
  logic [LW-1:0]     pf_line;
  logic [LW-1:0]     head_line;
  logic              unused_low_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshakes: a request transfers on a cycle where valid and ready are both high;
  // while lo_valid_o is high and lo_ready_i low the presented request is frozen, and
  // dem_address_i is consumed on the cycle dem_valid_i and dem_ready_o are both high.
  assign q_empty        = (q_cnt == '0);
  assign q_full         = (q_cnt == QCW'(QDEPTH));
  assign hs             = lo_valid_o && lo_ready_i;
  assign free           = (state == IDLE) || hs;
  assign fill_eff       = lo_fill_i && (out_cnt != '0);
  assign cnt_after_fill = out_cnt - CW'(fill_eff);
  assign space_ok       = (32'(cnt_after_fill) + 32'(hs)) < 32'(MSHR_COUNT);
  assign pf_elig        = !q_empty && !flush_i && (32'(out_cnt) < 32'(PF_THRESHOLD));
  assign force_pf       = (32'(starve) == 32'(STARVE_MAX)) && pf_elig;
  assign dem_ready_o    = free && space_ok && !force_pf;
  assign dem_grant      = dem_ready_o && dem_valid_i;
  assign pf_grant       = free && pf_elig && !dem_grant;

  assign pf_line   = pf_address_i[WIDTH-1:LOGLINE];
  assign head_line = q_line[rd_ptr];

  // Line offsets never matter here: both addresses are reduced to line granularity.
  assign unused_low_bits = ^{dem_address_i[LOGLINE-1:0], pf_address_i[LOGLINE-1:0]};

  always_comb begin
    dup_q = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld[i] && (q_line[i] == pf_line)) dup_q = 1'b1;
    end
  end

  // A prefetch already sitting in the output register counts as a duplicate too.
  assign dup_out = lo_valid_o && (lo_address_o[WIDTH-1:LOGLINE] == pf_line);
  assign pf_enq  = pf_valid_i && !flush_i && !q_full && !dup_q && !dup_out;
  assign pf_drop = pf_valid_i && !flush_i && (q_full || dup_q || dup_out);

  always_ff @(posedge clk) begin
    if (pf_enq) q_line[wr_ptr] <= pf_line;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_vld  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (flush_i) begin
      q_vld  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (pf_grant) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_inc(rd_ptr);
      end
      if (pf_enq) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      q_cnt <= q_cnt + QCW'(pf_enq) - QCW'(pf_grant);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt       <= '0;
      starve        <= '0;
      pf_drop_cnt_o <= '0;
    end else begin
      out_cnt <= cnt_after_fill + CW'(hs);
      if (pf_grant || q_empty) begin
        starve <= '0;
      end else if (dem_grant && (32'(starve) != 32'(STARVE_MAX))) begin
        starve <= starve + SW'(1);
      end
      if (pf_drop && (pf_drop_cnt_o != 16'hFFFF)) begin
        pf_drop_cnt_o <= pf_drop_cnt_o + 16'd1;
      end
    end
  end

  // Output register doubles as the FSM: it only reloads on a free cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      lo_valid_o       <= 1'b0;
      lo_is_prefetch_o <= 1'b0;
      lo_address_o     <= '0;
    end else if (free) begin
      if (dem_grant) begin
        state            <= HOLD_DEM;
        lo_valid_o       <= 1'b1;
        lo_is_prefetch_o <= 1'b0;
        lo_address_o     <= {dem_address_i[WIDTH-1:LOGLINE], {LOGLINE{1'b0}}};
      end else if (pf_grant) begin
        state            <= HOLD_PF;
        lo_valid_o       <= 1'b1;
        lo_is_prefetch_o <= 1'b1;
        lo_address_o     <= {head_line, {LOGLINE{1'b0}}};
      end else begin
        state            <= IDLE;
        lo_valid_o       <= 1'b0;
        lo_is_prefetch_o <= 1'b0;
      end
    end
  end

  assign outstanding_o = out_cnt;
  assign state_o       = state;

endmodule

// File: tb/tb_prefetch_issue_scheduler.sv
// Bench for prefetch_issue_scheduler: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_prefetch_issue_scheduler;

  localparam int WIDTH   = 64;
  localparam int QDEPTH  = 8;
  localparam int MSHR    = 16;
  localparam int PFTH    = 12;
  localparam int STARVE  = 4;
  localparam int LOGLINE = 6;
  localparam int LW      = WIDTH - LOGLINE;
  localparam int NV      = 17;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             dem_valid_i;
  logic [WIDTH-1:0] dem_address_i;
  logic             dem_ready_o;
  logic             pf_valid_i;
  logic [WIDTH-1:0] pf_address_i;
  logic             flush_i;
  logic             lo_ready_i;
  logic             lo_fill_i;
  logic             lo_valid_o;
  logic [WIDTH-1:0] lo_address_o;
  logic             lo_is_prefetch_o;
  logic [4:0]       outstanding_o;
  logic [15:0]      pf_drop_cnt_o;
  logic [1:0]       state_o;

  int total = 0;
  int bad   = 0;

  prefetch_issue_scheduler #(
    .WIDTH(WIDTH), .QDEPTH(QDEPTH), .MSHR_COUNT(MSHR),
    .PF_THRESHOLD(PFTH), .STARVE_MAX(STARVE), .LOGLINE(LOGLINE)
  ) dut (
    .clk(clk), .rst(rst),
    .dem_valid_i(dem_valid_i), .dem_address_i(dem_address_i), .dem_ready_o(dem_ready_o),
    .pf_valid_i(pf_valid_i), .pf_address_i(pf_address_i), .flush_i(flush_i),
    .lo_ready_i(lo_ready_i), .lo_fill_i(lo_fill_i), .lo_valid_o(lo_valid_o),
    .lo_address_o(lo_address_o), .lo_is_prefetch_o(lo_is_prefetch_o),
    .outstanding_o(outstanding_o), .pf_drop_cnt_o(pf_drop_cnt_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic idle_inputs();
    dem_valid_i   = 1'b0;
    dem_address_i = '0;
    pf_valid_i    = 1'b0;
    pf_address_i  = '0;
    flush_i       = 1'b0;
    lo_ready_i    = 1'b0;
    lo_fill_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        dv;
    logic [63:0] da;
    logic        pv;
    logic [63:0] pa;
    logic        fl;
    logic        rdy;
    logic        fill;
    logic        e_drdy;
    logic        e_lv;
    logic [63:0] e_la;
    logic        e_lpf;
    int          e_out;
    int          e_drop;
  } vec_t;

  vec_t tbl[NV];

  function automatic vec_t mk(logic dv, logic [63:0] da, logic pv, logic [63:0] pa,
                              logic fl, logic rdy, logic fill, logic e_drdy, logic e_lv,
                              logic [63:0] e_la, logic e_lpf, int e_out, int e_drop);
    vec_t v;
    v.dv = dv; v.da = da; v.pv = pv; v.pa = pa; v.fl = fl; v.rdy = rdy; v.fill = fill;
    v.e_drdy = e_drdy; v.e_lv = e_lv; v.e_la = e_la; v.e_lpf = e_lpf;
    v.e_out = e_out; v.e_drop = e_drop;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [LW-1:0] m_q[$];
  logic          m_hv;
  logic          m_hpf;
  logic [63:0]   m_ha;
  int            m_out;
  int            m_starve;
  int            m_drop;

  task automatic model_reset();
    m_q.delete();
    m_hv = 1'b0; m_hpf = 1'b0; m_ha = '0;
    m_out = 0; m_starve = 0; m_drop = 0;
  endtask

  task automatic model_step(input int cyc);
    bit hs, free, fill, elig, force_pf, drdy, dg, pg, dup, push;
    int after;
    logic [LW-1:0] line, head;
    head     = '0;
    hs       = m_hv && lo_ready_i;
    free     = !m_hv || hs;
    fill     = lo_fill_i && (m_out > 0);
    after    = m_out - int'(fill);
    elig     = (m_q.size() > 0) && !flush_i && (m_out < PFTH);
    force_pf = (m_starve == STARVE) && elig;
    drdy     = free && (after + int'(hs) < MSHR) && !force_pf;

    check($sformatf("rnd%0d dem_ready", cyc), dem_ready_o, drdy);
    check($sformatf("rnd%0d lo_valid", cyc), lo_valid_o, m_hv);
    check($sformatf("rnd%0d outstanding", cyc), outstanding_o, m_out);
    check($sformatf("rnd%0d drop_cnt", cyc), pf_drop_cnt_o, m_drop);
    if (m_hv) begin
      check($sformatf("rnd%0d lo_address", cyc), lo_address_o, m_ha);
      check($sformatf("rnd%0d lo_is_pf", cyc), lo_is_prefetch_o, m_hpf);
    end

    dg   = drdy && dem_valid_i;
    pg   = free && elig && !dg;
    line = pf_address_i[63:6];
    dup  = m_hv && (m_ha[63:6] == line);
    foreach (m_q[k]) if (m_q[k] == line) dup = 1'b1;
    push = pf_valid_i && !flush_i && (m_q.size() < QDEPTH) && !dup;
    if (pf_valid_i && !flush_i && !push && m_drop < 65535) m_drop++;

    if (pg || m_q.size() == 0) m_starve = 0;
    else if (dg && m_starve < STARVE) m_starve++;

    if (pg) head = m_q.pop_front();
    if (flush_i) m_q.delete();
    else if (push) m_q.push_back(line);

    if (free) begin
      if (dg) begin
        m_hv = 1'b1; m_hpf = 1'b0; m_ha = {dem_address_i[63:6], 6'b0};
      end else if (pg) begin
        m_hv = 1'b1; m_hpf = 1'b1; m_ha = {head, 6'b0};
      end else begin
        m_hv = 1'b0; m_hpf = 1'b0;
      end
    end
    m_out = after + int'(hs);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int  grants;
    bit  found;
    bit  prev_drdy;
    int  pf_seen;
    int  fill_pct;
    int  rdy_pct;

    tbl[0]  = mk(0, 64'h0,    0, 64'h0,    0, 1, 0,  1, 0, 64'h0,    0, 0, 0);
    tbl[1]  = mk(1, 64'h1040, 0, 64'h0,    0, 1, 0,  1, 0, 64'h0,    0, 0, 0);
    tbl[2]  = mk(0, 64'h0,    0, 64'h0,    0, 1, 0,  1, 1, 64'h1040, 0, 0, 0);
    tbl[3]  = mk(0, 64'h0,    0, 64'h0,    0, 1, 0,  1, 0, 64'h0,    0, 1, 0);
    tbl[4]  = mk(0, 64'h0,    1, 64'h2000, 0, 1, 0,  1, 0, 64'h0,    0, 1, 0);
    tbl[5]  = mk(0, 64'h0,    1, 64'h2010, 0, 1, 0,  1, 0, 64'h0,    0, 1, 0);
    tbl[6]  = mk(0, 64'h0,    0, 64'h0,    0, 1, 0,  1, 1, 64'h2000, 1, 1, 1);
    tbl[7]  = mk(0, 64'h0,    0, 64'h0,    0, 1, 1,  1, 0, 64'h0,    0, 2, 1);
    tbl[8]  = mk(0, 64'h0,    0, 64'h0,    0, 1, 1,  1, 0, 64'h0,    0, 1, 1);
    tbl[9]  = mk(0, 64'h0,    0, 64'h0,    0, 1, 0,  1, 0, 64'h0,    0, 0, 1);
    tbl[10] = mk(1, 64'h3fff, 0, 64'h0,    0, 0, 0,  1, 0, 64'h0,    0, 0, 1);
    tbl[11] = mk(0, 64'h0,    0, 64'h0,    0, 0, 0,  0, 1, 64'h3fc0, 0, 0, 1);
    tbl[12] = mk(0, 64'h0,    0, 64'h0,    0, 0, 1,  0, 1, 64'h3fc0, 0, 0, 1);
    tbl[13] = mk(0, 64'h0,    0, 64'h0,    0, 1, 0,  1, 1, 64'h3fc0, 0, 0, 1);
    tbl[14] = mk(0, 64'h0,    0, 64'h0,    0, 1, 0,  1, 0, 64'h0,    0, 1, 1);
    tbl[15] = mk(0, 64'h0,    0, 64'h0,    0, 1, 1,  1, 0, 64'h0,    0, 1, 1);
    tbl[16] = mk(0, 64'h0,    0, 64'h0,    0, 1, 0,  1, 0, 64'h0,    0, 0, 1);

    // Table vectors from reset: demand issue, same-line prefetch drop, misaligned hold.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      dem_valid_i = tbl[i].dv;  dem_address_i = tbl[i].da;
      pf_valid_i  = tbl[i].pv;  pf_address_i  = tbl[i].pa;
      flush_i     = tbl[i].fl;  lo_ready_i    = tbl[i].rdy;  lo_fill_i = tbl[i].fill;
      @(negedge clk);
      check($sformatf("vec%0d dem_ready", i), dem_ready_o, tbl[i].e_drdy);
      check($sformatf("vec%0d lo_valid", i), lo_valid_o, tbl[i].e_lv);
      check($sformatf("vec%0d outstanding", i), outstanding_o, tbl[i].e_out);
      check($sformatf("vec%0d drop_cnt", i), pf_drop_cnt_o, tbl[i].e_drop);
      if (tbl[i].e_lv) begin
        check($sformatf("vec%0d lo_address", i), lo_address_o, tbl[i].e_la);
        check($sformatf("vec%0d lo_is_pf", i), lo_is_prefetch_o, tbl[i].e_lpf);
      end
      tick();
    end

    // Starvation: one queued prefetch under continuous demand.
    do_reset();
    lo_ready_i = 1'b1; lo_fill_i = 1'b1;
    dem_valid_i = 1'b1; dem_address_i = 64'h100;
    pf_valid_i = 1'b1; pf_address_i = 64'h5000;
    tick();
    pf_valid_i = 1'b0;
    grants = 0; found = 1'b0; prev_drdy = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      dem_address_i = 64'h200 + 64'(c) * 64;
      @(negedge clk);
      if (lo_valid_o && lo_is_prefetch_o) begin
        found = 1'b1;
        check("starve pf_address", lo_address_o, 64'h5000);
        check("starve dem_ready at force", prev_drdy, 1'b0);
      end else begin
        if (dem_ready_o) grants++;
        prev_drdy = dem_ready_o;
      end
      tick();
    end
    check("starve pf issued", found, 1'b1);
    check("starve demand grants", grants, 4);

    // Threshold hold: 12 outstanding, prefetch waits until a fill.
    do_reset();
    lo_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      dem_valid_i = 1'b1; dem_address_i = 64'h10000 + 64'(i) * 64;
      tick();
    end
    dem_valid_i = 1'b0;
    tick();
    pf_valid_i = 1'b1; pf_address_i = 64'h6000;
    @(negedge clk);
    check("thr outstanding 12", outstanding_o, 12);
    tick();
    pf_valid_i = 1'b0;
    pf_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (lo_valid_o) pf_seen++;
      tick();
    end
    check("thr prefetch held", pf_seen, 0);
    lo_fill_i = 1'b1;
    tick();
    lo_fill_i = 1'b0;
    @(negedge clk);
    check("thr outstanding 11", outstanding_o, 11);
    check("thr not yet valid", lo_valid_o, 1'b0);
    tick();
    @(negedge clk);
    check("thr pf valid", lo_valid_o, 1'b1);
    check("thr pf flag", lo_is_prefetch_o, 1'b1);
    check("thr pf address", lo_address_o, 64'h6000);

    // Queue full while a demand is stalled, then flush.
    do_reset();
    dem_valid_i = 1'b1; dem_address_i = 64'h7000;
    tick();
    dem_valid_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pf_valid_i = 1'b1; pf_address_i = 64'h8000 + 64'(i) * 64;
      tick();
    end
    pf_valid_i = 1'b0;
    @(negedge clk);
    check("full drop_cnt", pf_drop_cnt_o, 1);
    tick();
    flush_i = 1'b1; pf_valid_i = 1'b1; pf_address_i = 64'h9000;
    tick();
    flush_i = 1'b0; pf_valid_i = 1'b0;
    @(negedge clk);
    check("flush drop_cnt", pf_drop_cnt_o, 1);
    check("flush held valid", lo_valid_o, 1'b1);
    check("flush held address", lo_address_o, 64'h7000);
    check("flush held is_pf", lo_is_prefetch_o, 1'b0);
    tick();
    lo_ready_i = 1'b1;
    pf_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lo_valid_o && lo_is_prefetch_o) pf_seen++;
      tick();
    end
    check("flush no prefetch issued", pf_seen, 0);
    check("flush outstanding", outstanding_o, 1);

    // Reset while a prefetch is held.
    do_reset();
    lo_ready_i = 1'b1; dem_valid_i = 1'b1; dem_address_i = 64'h1000;
    tick();
    dem_valid_i = 1'b0;
    tick();
    lo_ready_i = 1'b0; pf_valid_i = 1'b1; pf_address_i = 64'hA000;
    tick();
    pf_valid_i = 1'b0;
    tick();
    @(negedge clk);
    check("rst pre valid", lo_valid_o, 1'b1);
    check("rst pre is_pf", lo_is_prefetch_o, 1'b1);
    check("rst pre outstanding", outstanding_o, 1);
    #2 rst = 1'b0;
    #1;
    check("rst lo_valid", lo_valid_o, 1'b0);
    check("rst is_pf", lo_is_prefetch_o, 1'b0);
    check("rst address", lo_address_o, 64'h0);
    check("rst outstanding", outstanding_o, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst release dem_ready", dem_ready_o, 1'b1);
    tick();
    tick();
    @(negedge clk);
    check("rst queue empty", lo_valid_o, 1'b0);
    tick();

    // Random traffic against the model, in phases of differing fill/ready pressure.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      fill_pct = (c < 1000) ? 30 : (c < 2000) ? 8 : 55;
      rdy_pct  = (c < 2000) ? 65 : 40;
      dem_valid_i   = ($urandom_range(0, 99) < 55);
      dem_address_i = 64'h4000 + 64'($urandom_range(0, 23)) * 64 + 64'($urandom_range(0, 63));
      pf_valid_i    = ($urandom_range(0, 99) < 50);
      pf_address_i  = 64'h4000 + 64'($urandom_range(0, 23)) * 64 + 64'($urandom_range(0, 63));
      flush_i       = ($urandom_range(0, 99) < 2);
      lo_ready_i    = ($urandom_range(0, 99) < rdy_pct);
      lo_fill_i     = ($urandom_range(0, 99) < fill_pct);
      @(negedge clk);
      model_step(c);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
